mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter LEN_W, default 9: width of the word-count input (max copy = 2^(LEN_W-1) = 256 words).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: request pulse; sampled only in IDLE.
REQ-005 SHALL have port src_addr, input, 32: first source word address; sampled with start.
REQ-006 SHALL have port dst_addr, input, 32: first destination word address; sampled with start.
REQ-007 SHALL have port len, input, LEN_W: word count; sampled with start; legal range 0..256.
REQ-008 SHALL have port abort, input, 1: cancel an in-progress copy.
REQ-009 SHALL have port busy, output, 1: copy in progress (RUN or DRAIN).
REQ-010 SHALL have port done, output, 1: one-cycle pulse on normal completion.
REQ-011 SHALL have port aborted, output, 1: one-cycle pulse on abort completion.
REQ-012 SHALL have port mem_rd_addr, output, 32: to main memory rd_addr.
REQ-013 SHALL have port mem_rd_data, input, 32: from main memory data_out, valid one cycle after mem_rd_addr (registered read).
REQ-014 SHALL have ports mem_wr_addr (output, 32), mem_wr_data (output, 32) and mem_wr_en (output, 1): to main memory write port.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, FIN; all outputs registered.
REQ-016 IDLE: start=1 with len=0 SHALL go to FIN; no memory reads or writes occur.
REQ-017 IDLE: start=1 with len>0 SHALL latch src, dst and len, select direction, and go to RUN.
REQ-018 Direction SHALL be descending iff dst_addr > src_addr and dst_addr < src_addr+len (32-bit compare/add); otherwise ascending, including dst_addr == src_addr.
REQ-019 RUN, read i (i = 0..len-1, one per cycle) SHALL drive mem_rd_addr = src+i ascending or src+len-1-i descending.
REQ-020 The cycle after read i, SHALL assert mem_wr_en=1 with mem_wr_addr = the matching dst offset and mem_wr_data = mem_rd_data.
REQ-021 After the last read SHALL go to DRAIN for exactly one cycle, which carries the final write; then FIN.
REQ-022 FIN SHALL pulse done=1 for one cycle and return to IDLE.
REQ-023 Timing: for start sampled at edge 0, reads SHALL occur in cycles 1..len, writes in cycles 2..len+1, and done in cycle len+2; len=0 SHALL give done in cycle 1.
REQ-024 busy SHALL be 1 exactly in RUN and DRAIN.
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 Address arithmetic SHALL be modulo 2^32 (wrap from 0xFFFFFFFF to 0 ascending, and 0 to 0xFFFFFFFF descending).
REQ-027 When mem_wr_en=0, mem_wr_addr and mem_wr_data SHALL be 0.
REQ-028 mem_rd_addr SHALL hold its last value outside RUN; it is 0 after reset.
REQ-029 abort=1 in RUN SHALL stop reads at once and still complete the write for a read already issued in the previous cycle.
REQ-030 After an abort in RUN, SHALL go to FIN, pulse aborted (not done), then return to IDLE.
REQ-031 abort=1 in DRAIN SHALL be ignored, so the copy completes normally; abort SHALL also be ignored in IDLE and FIN.
REQ-032 Simultaneous start and abort in IDLE SHALL start the copy, because abort is ignored in IDLE.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, aborted=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0 and mem_rd_addr=0, without waiting for clk.
REQ-034 Reset mid-copy SHALL discard the copy with no further writes and no done pulse.
REQ-035 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-036 Ascending copy: mem[0x10..0x13] = A,B,C,D; start src=0x10, dst=0x40, len=4 -> writes to 0x40..0x43 = A..D in cycles 2..5; done in cycle 6; busy high in cycles 1..5.
REQ-037 Overlapping forward copy: mem[0x20..0x27] = 0..7; src=0x20, dst=0x22, len=6 -> descending order; mem[0x22..0x27] = 0..5 at the end.
REQ-038 Overlapping backward copy: mem[0x20..0x27] = 0..7; src=0x22, dst=0x20, len=6 -> ascending order; mem[0x20..0x25] = 2..7 at the end.
REQ-039 len=0 -> done in cycle 1, no mem_wr_en; len=256 with src=0xFFFFFF80 -> mem_rd_addr wraps to 0x00000000 at read 128, 256 writes.
REQ-040 abort asserted in cycle 3 of a len=8 copy -> exactly 2 writes, aborted pulse, no done; start during RUN ignored.
REQ-041 rst_n low in cycle 3 of a len=8 copy -> mem_wr_en=0 and busy=0 at once; memory holds only the writes made before reset.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Word-granular memory-to-memory copy engine with overlap-safe direction selection.
// Drives a single-port-read / single-port-write memory whose read data lags the address by one cycle.
module mem_copy_engine #(
    parameter int unsigned LEN_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [31:0]      mem_rd_addr_o,
    input  logic [31:0]      mem_rd_data_i,
    output logic [31:0]      mem_wr_addr_o,
    output logic [31:0]      mem_wr_data_o,
    output logic             mem_wr_en_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               desc_q, desc_d;
    logic [31:0]        rd_addr_q, rd_addr_d;
    logic [31:0]        dst_ptr_q, dst_ptr_d;
    logic [31:0]        wr_addr_q, wr_addr_d;
    logic               wr_en_q, wr_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic [31:0]        len_ext;
    logic [31:0]        last_off;
    logic [31:0]        src_end;
    logic               overlap;

    assign len_ext  = 32'(len_i);
    assign last_off = len_ext - 32'd1;
    assign src_end  = src_addr_i + len_ext;
    // Copy from the top down when the destination starts inside the source window.
    assign overlap  = (dst_addr_i > src_addr_i) && (dst_addr_i < src_end);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        desc_d    = desc_q;
        rd_addr_d = rd_addr_q;
        dst_ptr_d = dst_ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = 32'd0;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_d = StFin;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = StRun;
                        rem_d     = len_i;
                        desc_d    = overlap;
                        rd_addr_d = overlap ? src_addr_i + last_off : src_addr_i;
                        dst_ptr_d = overlap ? dst_addr_i + last_off : dst_addr_i;
                    end
                end
            end
            StRun: begin
                if (abort_i) begin
                    // The read on the bus this cycle is dropped; no write follows it.
                    state_d   = StFin;
                    aborted_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = dst_ptr_q;
                    dst_ptr_d = desc_q ? dst_ptr_q - 32'd1 : dst_ptr_q + 32'd1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end else begin
                        rem_d     = rem_q - LEN_W'(1);
                        rd_addr_d = desc_q ? rd_addr_q - 32'd1 : rd_addr_q + 32'd1;
                    end
                end
            end
            StDrain: begin
                state_d = StFin;
                done_d  = 1'b1;
            end
            StFin: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StRun) || (state_d == StDrain);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            desc_q    <= 1'b0;
            rd_addr_q <= 32'd0;
            dst_ptr_q <= 32'd0;
            wr_addr_q <= 32'd0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            desc_q    <= desc_d;
            rd_addr_q <= rd_addr_d;
            dst_ptr_q <= dst_ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign aborted_o     = aborted_q;
    assign mem_rd_addr_o = rd_addr_q;
    assign mem_wr_addr_o = wr_addr_q;
    assign mem_wr_en_o   = wr_en_q;
    // Read data arrives the cycle the write is issued, so it is forwarded rather than re-registered.
    assign mem_wr_data_o = wr_en_q ? mem_rd_data_i : 32'd0;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 1024-word registered-read memory model.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'd0;
    logic [31:0] dst_addr = 32'd0;
    logic [8:0]  len = 9'd0;
    logic        abort = 1'b0;
    logic        busy, done, aborted, wr_en;
    logic [31:0] rd_addr, rd_data, wr_addr, wr_data;

    logic [31:0] mem [0:1023];
    logic        tb_we = 1'b0;
    logic [9:0]  tb_waddr = 10'd0;
    logic [31:0] tb_wdata = 32'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.LEN_W(9)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .src_addr_i    (src_addr),
        .dst_addr_i    (dst_addr),
        .len_i         (len),
        .abort_i       (abort),
        .busy_o        (busy),
        .done_o        (done),
        .aborted_o     (aborted),
        .mem_rd_addr_o (rd_addr),
        .mem_rd_data_i (rd_data),
        .mem_wr_addr_o (wr_addr),
        .mem_wr_data_o (wr_data),
        .mem_wr_en_o   (wr_en)
    );

    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wdata;
        else if (wr_en) mem[wr_addr[9:0]] <= wr_data;
        rd_data <= mem[rd_addr[9:0]];
    end

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    // Call just after a rising edge in IDLE; returns 1 time unit into cycle 1.
    task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [8:0] n);
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL reset_aborted got=%b exp=0", aborted); end
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        checks++; if (wr_addr !== 32'd0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
        checks++; if (wr_data !== 32'd0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
        checks++; if (rd_addr !== 32'd0) begin failures++; $display("FAIL reset_rd_addr got=%h exp=0", rd_addr); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ascending();
        for (int i = 0; i < 4; i++) poke(10'(32'h10 + i), 32'hA5A5_0000 + i);
        for (int i = 0; i < 4; i++) poke(10'(32'h40 + i), 32'hDEAD_0000);
        kick(32'h10, 32'h40, 9'd4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== (k <= 5)) begin failures++; $display("FAIL asc_busy cyc=%0d got=%b", k, busy); end
            checks++;
            if (done !== (k == 6)) begin failures++; $display("FAIL asc_done cyc=%0d got=%b", k, done); end
            checks++;
            if (wr_en !== (k >= 2 && k <= 5)) begin failures++; $display("FAIL asc_wr_en cyc=%0d got=%b", k, wr_en); end
            checks++;
            if (rd_addr !== ((k <= 4) ? 32'h10 + 32'(k) - 1 : 32'h13)) begin
                failures++; $display("FAIL asc_rd_addr cyc=%0d got=%h", k, rd_addr);
            end
            if (k >= 2 && k <= 5) begin
                checks++;
                if (wr_addr !== 32'h40 + 32'(k) - 2 || wr_data !== 32'hA5A5_0000 + 32'(k) - 2) begin
                    failures++; $display("FAIL asc_write cyc=%0d addr=%h data=%h", k, wr_addr, wr_data);
                end
            end else begin
                checks++;
                if (wr_addr !== 32'd0 || wr_data !== 32'd0) begin
                    failures++; $display("FAIL asc_idle_bus cyc=%0d addr=%h data=%h", k, wr_addr, wr_data);
                end
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[10'(32'h40 + i)] !== 32'hA5A5_0000 + 32'(i)) begin
                failures++; $display("FAIL asc_mem i=%0d got=%h exp=%h", i, mem[10'(32'h40 + i)], 32'hA5A5_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_overlap(input logic fwd);
        logic [31:0] s, d, exp_rd, exp_wr;
        int done_cyc;
        s = fwd ? 32'h20 : 32'h22;
        d = fwd ? 32'h22 : 32'h20;
        exp_rd = fwd ? 32'h25 : 32'h22;
        exp_wr = fwd ? 32'h27 : 32'h20;
        done_cyc = 0;
        for (int i = 0; i < 8; i++) poke(10'(32'h20 + i), 32'(i));
        kick(s, d, 9'd6);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (rd_addr !== exp_rd) begin failures++; $display("FAIL ovl_first_rd fwd=%b got=%h exp=%h", fwd, rd_addr, exp_rd); end
            end
            if (k == 2) begin
                checks++;
                if (wr_addr !== exp_wr) begin failures++; $display("FAIL ovl_first_wr fwd=%b got=%h exp=%h", fwd, wr_addr, exp_wr); end
            end
            if (done) done_cyc = k;
            @(posedge clk); #1;
        end
        checks++;
        if (done_cyc != 8) begin failures++; $display("FAIL ovl_done fwd=%b got=%0d exp=8", fwd, done_cyc); end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] e;
            if (fwd) e = (i < 2) ? 32'(i) : 32'(i - 2);
            else     e = (i < 6) ? 32'(i + 2) : 32'(i);
            checks++;
            if (mem[10'(32'h20 + i)] !== e) begin
                failures++; $display("FAIL ovl_mem fwd=%b i=%0d got=%h exp=%h", fwd, i, mem[10'(32'h20 + i)], e);
            end
        end
    endtask

    task automatic test_len_zero();
        int writes, dones;
        writes = 0; dones = 0;
        kick(32'h10, 32'h50, 9'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (done !== 1'b1) begin failures++; $display("FAIL len0_done got=%b exp=1", done); end
            end
            checks++;
            if (busy !== 1'b0) begin failures++; $display("FAIL len0_busy cyc=%0d got=%b", k, busy); end
            if (wr_en) writes++;
            if (done) dones++;
            @(posedge clk); #1;
        end
        checks++; if (writes != 0) begin failures++; $display("FAIL len0_writes got=%0d exp=0", writes); end
        checks++; if (dones != 1) begin failures++; $display("FAIL len0_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_wrap();
        int writes, done_cyc;
        writes = 0; done_cyc = 0;
        for (int i = 0; i < 256; i++) poke(10'(32'hFFFF_FF80 + i), 32'hC000_0000 + i);
        kick(32'hFFFF_FF80, 32'h200, 9'd256);
        for (int k = 1; k <= 262; k++) begin
            @(negedge clk);
            if (k == 128) begin
                checks++;
                if (rd_addr !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_rd127 got=%h exp=ffffffff", rd_addr); end
            end
            if (k == 129) begin
                checks++;
                if (rd_addr !== 32'h0) begin failures++; $display("FAIL wrap_rd128 got=%h exp=00000000", rd_addr); end
            end
            if (wr_en) writes++;
            if (done && done_cyc == 0) done_cyc = k;
            @(posedge clk); #1;
        end
        checks++; if (writes != 256) begin failures++; $display("FAIL wrap_writes got=%0d exp=256", writes); end
        checks++; if (done_cyc != 258) begin failures++; $display("FAIL wrap_done got=%0d exp=258", done_cyc); end
        for (int i = 0; i < 256; i += 37) begin
            checks++;
            if (mem[10'(32'h200 + i)] !== 32'hC000_0000 + 32'(i)) begin
                failures++; $display("FAIL wrap_mem i=%0d got=%h", i, mem[10'(32'h200 + i)]);
            end
        end
    endtask

    task automatic test_abort_run();
        int writes, dones, aborts, abort_cyc, busy_late;
        writes = 0; dones = 0; aborts = 0; abort_cyc = 0; busy_late = 0;
        for (int i = 0; i < 8; i++) poke(10'(32'h100 + i), 32'h5000 + i);
        for (int i = 0; i < 8; i++) poke(10'(32'h140 + i), 32'hDEAD_0000);
        kick(32'h100, 32'h140, 9'd8);
        for (int k = 1; k <= 14; k++) begin
            start = (k == 2);
            if (k == 2) begin src_addr = 32'h300; dst_addr = 32'h340; len = 9'd5; end
            abort = (k == 3);
            @(negedge clk);
            if (wr_en) writes++;
            if (done) dones++;
            if (aborted) begin aborts++; abort_cyc = k; end
            if (k >= 5 && busy) busy_late++;
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0;
        checks++; if (writes != 2) begin failures++; $display("FAIL abort_writes got=%0d exp=2", writes); end
        checks++; if (dones != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", dones); end
        checks++; if (aborts != 1 || abort_cyc != 4) begin
            failures++; $display("FAIL abort_pulse count=%0d cyc=%0d exp=1@4", aborts, abort_cyc);
        end
        checks++; if (busy_late != 0) begin failures++; $display("FAIL abort_busy_after got=%0d exp=0", busy_late); end
        checks++; if (mem[10'h141] !== 32'h5001) begin failures++; $display("FAIL abort_mem1 got=%h exp=00005001", mem[10'h141]); end
        checks++; if (mem[10'h142] !== 32'hDEAD_0000) begin failures++; $display("FAIL abort_mem2 got=%h exp=dead0000", mem[10'h142]); end
    endtask

    task automatic test_abort_drain();
        int writes, done_cyc, aborts;
        writes = 0; done_cyc = 0; aborts = 0;
        for (int i = 0; i < 3; i++) poke(10'(32'h10 + i), 32'h7700 + i);
        kick(32'h10, 32'h60, 9'd3);
        for (int k = 1; k <= 7; k++) begin
            abort = (k == 4);
            @(negedge clk);
            if (wr_en) writes++;
            if (done) done_cyc = k;
            if (aborted) aborts++;
            @(posedge clk); #1;
        end
        abort = 1'b0;
        checks++; if (writes != 3) begin failures++; $display("FAIL drain_abort_writes got=%0d exp=3", writes); end
        checks++; if (done_cyc != 5) begin failures++; $display("FAIL drain_abort_done got=%0d exp=5", done_cyc); end
        checks++; if (aborts != 0) begin failures++; $display("FAIL drain_abort_pulse got=%0d exp=0", aborts); end
        checks++; if (mem[10'h62] !== 32'h7702) begin failures++; $display("FAIL drain_abort_mem got=%h exp=00007702", mem[10'h62]); end
    endtask

    task automatic test_start_abort_idle();
        int done_cyc;
        done_cyc = 0;
        abort = 1'b1;
        kick(32'h10, 32'h70, 9'd2);
        abort = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL idle_abort_busy got=%b exp=1", busy); end
            end
            if (done) done_cyc = k;
            @(posedge clk); #1;
        end
        checks++; if (done_cyc != 4) begin failures++; $display("FAIL idle_abort_done got=%0d exp=4", done_cyc); end
    endtask

    task automatic test_reset_mid();
        int dones, busy_cyc;
        dones = 0; busy_cyc = 0;
        for (int i = 0; i < 8; i++) poke(10'(32'h100 + i), 32'h5000 + i);
        for (int i = 0; i < 8; i++) poke(10'(32'h180 + i), 32'hDEAD_0000);
        kick(32'h100, 32'h180, 9'd8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rstmid_wr_en got=%b exp=0", wr_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (rd_addr !== 32'd0) begin failures++; $display("FAIL rstmid_rd_addr got=%h exp=0", rd_addr); end
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        checks++; if (dones != 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", dones); end
        checks++; if (mem[10'h180] !== 32'h5000) begin failures++; $display("FAIL rstmid_mem0 got=%h exp=00005000", mem[10'h180]); end
        checks++; if (mem[10'h181] !== 32'hDEAD_0000) begin failures++; $display("FAIL rstmid_mem1 got=%h exp=dead0000", mem[10'h181]); end
        kick(32'h103, 32'h190, 9'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (busy && busy_cyc == 0) busy_cyc = k;
            @(posedge clk); #1;
        end
        checks++; if (busy_cyc != 1) begin failures++; $display("FAIL rstmid_restart got=%0d exp=1", busy_cyc); end
        checks++; if (mem[10'h190] !== 32'h5003) begin failures++; $display("FAIL rstmid_restart_mem got=%h exp=00005003", mem[10'h190]); end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_overlap(1'b1);
        test_overlap(1'b0);
        test_len_zero();
        test_wrap();
        test_abort_run();
        test_abort_drain();
        test_start_abort_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
